// File: rtl/hmr_backup_delay.sv
// Delay-and-commit pipeline for the HMR rapid-recovery backup state (regfile writes, CSR, PC).
// Items reach recovery storage only after DelayStages cycles free of lockstep mismatch.
module hmr_backup_delay #(
   parameter int unsigned NumWritePorts = 2,
   parameter int unsigned AddrWidth     = 5,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned CsrWidth      = 128,
   parameter int unsigned DelayStages   = 2,
   parameter int unsigned CntWidth      = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 backup_en_i,
   input  logic                                 mismatch_i,
   input  logic [NumWritePorts-1:0]             rf_we_i,
   input  logic [NumWritePorts*AddrWidth-1:0]   rf_waddr_i,
   input  logic [NumWritePorts*DataWidth-1:0]   rf_wdata_i,
   input  logic                                 csr_valid_i,
   input  logic [CsrWidth-1:0]                  csr_i,
   input  logic                                 pc_valid_i,
   input  logic [DataWidth-1:0]                 pc_i,
   output logic [NumWritePorts-1:0]             rf_we_o,
   output logic [NumWritePorts*AddrWidth-1:0]   rf_waddr_o,
   output logic [NumWritePorts*DataWidth-1:0]   rf_wdata_o,
   output logic                                 csr_valid_o,
   output logic [CsrWidth-1:0]                  csr_o,
   output logic                                 pc_valid_o,
   output logic [DataWidth-1:0]                 pc_o,
   output logic                                 pending_o,
   input  logic                                 clear_cnt_i,
   output logic [CntWidth-1:0]                  discard_cnt_o
);

   // The last register stage already lands in cycle t+DelayStages-1, so one stage fewer is stored.
   localparam int unsigned NumRegs  = (DelayStages > 0) ? DelayStages - 1 : 0;
   localparam int unsigned PopW     = $clog2(NumWritePorts * ((DelayStages > 0) ? DelayStages : 1) + 1);
   localparam int unsigned SumW     = ((CntWidth > PopW) ? CntWidth : PopW) + 1;
   localparam logic [CntWidth-1:0] CntMax = '1;

   if (DelayStages < 1 || DelayStages > 8) begin : g_bad_delay
      $error("hmr_backup_delay: DelayStages must lie in 1..8");
   end

   logic                               capture_c;
   logic [NumWritePorts-1:0]           we_dedup_c;
   logic [NumWritePorts-1:0]           cap_we_c;
   logic [NumWritePorts-1:0]           last_we_c;
   logic [NumWritePorts*AddrWidth-1:0] last_addr_c;
   logic [NumWritePorts*DataWidth-1:0] last_data_c;
   logic                               last_csr_v_c;
   logic [CsrWidth-1:0]                last_csr_c;
   logic                               last_pc_v_c;
   logic [DataWidth-1:0]               last_pc_c;
   logic                               pending_c;
   logic [PopW-1:0]                    stage_pop_c;
   logic [PopW-1:0]                    in_pop_c;
   logic [SumW-1:0]                    sum_c;
   logic [CntWidth-1:0]                cnt_q, cnt_d;

   // Same-cycle address collision: a higher-index port writing the same address wins.
   always_comb begin
      we_dedup_c = rf_we_i;
      for (int i = 0; i < int'(NumWritePorts); i++) begin
         for (int j = i + 1; j < int'(NumWritePorts); j++) begin
            if (rf_we_i[j] &&
                (rf_waddr_i[j*AddrWidth +: AddrWidth] == rf_waddr_i[i*AddrWidth +: AddrWidth])) begin
               we_dedup_c[i] = 1'b0;
            end
         end
      end
   end

   assign capture_c = backup_en_i & ~mismatch_i;
   assign cap_we_c  = capture_c ? we_dedup_c : '0;

   always_comb begin
      in_pop_c = '0;
      for (int p = 0; p < int'(NumWritePorts); p++) begin
         if (backup_en_i && we_dedup_c[p]) in_pop_c = in_pop_c + PopW'(1);
      end
   end

   if (NumRegs == 0) begin : g_pass
      assign last_we_c    = cap_we_c;
      assign last_addr_c  = rf_waddr_i;
      assign last_data_c  = rf_wdata_i;
      assign last_csr_v_c = capture_c & csr_valid_i;
      assign last_csr_c   = csr_i;
      assign last_pc_v_c  = capture_c & pc_valid_i;
      assign last_pc_c    = pc_i;
      assign pending_c    = 1'b0;
      assign stage_pop_c  = '0;
   end else begin : g_pipe
      logic [NumWritePorts-1:0]           we_q   [NumRegs];
      logic [NumWritePorts-1:0]           we_d   [NumRegs];
      logic [NumWritePorts*AddrWidth-1:0] addr_q [NumRegs];
      logic [NumWritePorts*AddrWidth-1:0] addr_d [NumRegs];
      logic [NumWritePorts*DataWidth-1:0] data_q [NumRegs];
      logic [NumWritePorts*DataWidth-1:0] data_d [NumRegs];
      logic [CsrWidth-1:0]                csr_q  [NumRegs];
      logic [CsrWidth-1:0]                csr_d  [NumRegs];
      logic [DataWidth-1:0]               pc_q   [NumRegs];
      logic [DataWidth-1:0]               pc_d   [NumRegs];
      logic [NumRegs-1:0]                 csr_v_q, csr_v_d, pc_v_q, pc_v_d;

      always_comb begin
         we_d    = we_q;
         addr_d  = addr_q;
         data_d  = data_q;
         csr_d   = csr_q;
         pc_d    = pc_q;
         csr_v_d = csr_v_q;
         pc_v_d  = pc_v_q;
         we_d[0]    = cap_we_c;
         csr_v_d[0] = capture_c & csr_valid_i;
         pc_v_d[0]  = capture_c & pc_valid_i;
         if (capture_c) begin
            addr_d[0] = rf_waddr_i;
            data_d[0] = rf_wdata_i;
            csr_d[0]  = csr_i;
            pc_d[0]   = pc_i;
         end
         // A mismatch drops every in-flight valid at the next edge.
         for (int k = 1; k < int'(NumRegs); k++) begin
            we_d[k]    = mismatch_i ? '0 : we_q[k-1];
            csr_v_d[k] = ~mismatch_i & csr_v_q[k-1];
            pc_v_d[k]  = ~mismatch_i & pc_v_q[k-1];
            addr_d[k]  = addr_q[k-1];
            data_d[k]  = data_q[k-1];
            csr_d[k]   = csr_q[k-1];
            pc_d[k]    = pc_q[k-1];
         end
      end

      always_comb begin
         pending_c   = 1'b0;
         stage_pop_c = '0;
         for (int k = 0; k < int'(NumRegs); k++) begin
            pending_c = pending_c | (|we_q[k]) | csr_v_q[k] | pc_v_q[k];
            for (int p = 0; p < int'(NumWritePorts); p++) begin
               stage_pop_c = stage_pop_c + PopW'(we_q[k][p]);
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int k = 0; k < int'(NumRegs); k++) begin
               we_q[k]   <= '0;
               addr_q[k] <= '0;
               data_q[k] <= '0;
               csr_q[k]  <= '0;
               pc_q[k]   <= '0;
            end
            csr_v_q <= '0;
            pc_v_q  <= '0;
         end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            csr_q   <= csr_d;
            pc_q    <= pc_d;
            csr_v_q <= csr_v_d;
            pc_v_q  <= pc_v_d;
         end
      end

      assign last_we_c    = we_q[NumRegs-1];
      assign last_addr_c  = addr_q[NumRegs-1];
      assign last_data_c  = data_q[NumRegs-1];
      assign last_csr_v_c = csr_v_q[NumRegs-1];
      assign last_csr_c   = csr_q[NumRegs-1];
      assign last_pc_v_c  = pc_v_q[NumRegs-1];
      assign last_pc_c    = pc_q[NumRegs-1];
   end

   // Saturating discard counter; a clear in a mismatch cycle keeps only that cycle's increment.
   always_comb begin
      cnt_d = cnt_q;
      sum_c = SumW'(clear_cnt_i ? '0 : cnt_q) + SumW'(stage_pop_c) + SumW'(in_pop_c);
      if (clear_cnt_i) cnt_d = '0;
      if (mismatch_i) cnt_d = (sum_c > SumW'(CntMax)) ? CntMax : CntWidth'(sum_c);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign rf_we_o       = last_we_c & {NumWritePorts{~mismatch_i}};
   assign rf_waddr_o    = last_addr_c;
   assign rf_wdata_o    = last_data_c;
   assign csr_valid_o   = last_csr_v_c & ~mismatch_i;
   assign csr_o         = last_csr_c;
   assign pc_valid_o    = last_pc_v_c & ~mismatch_i;
   assign pc_o          = last_pc_c;
   assign pending_o     = pending_c;
   assign discard_cnt_o = cnt_q;

endmodule

// File: tb/tb_hmr_backup_delay.sv
// Bench for hmr_backup_delay: directed scenarios plus random traffic against a cycle-history model.
module tb_hmr_backup_delay;
   localparam int unsigned NP = 2, AW = 5, DW = 32, CW = 128, DS = 2, CNTW = 4;
   localparam int L      = int'(DS) - 1;
   localparam int MAXC   = 1024;
   localparam int CNTMAX = (1 << CNTW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          en, mm, clr, csr_v, pc_v;
   logic [NP-1:0] we;
   logic [AW-1:0] addr [NP];
   logic [DW-1:0] data [NP];
   logic [CW-1:0] csr;
   logic [DW-1:0] pc;
   logic [NP*AW-1:0] addr_pk;
   logic [NP*DW-1:0] data_pk;

   logic          n_en, n_mm, n_clr, n_csrv, n_pcv;
   logic [NP-1:0] n_we;
   logic [AW-1:0] n_addr [NP];
   logic [DW-1:0] n_data [NP];
   logic [CW-1:0] n_csr;
   logic [DW-1:0] n_pc;

   logic [NP-1:0]    rf_we_o;
   logic [NP*AW-1:0] rf_waddr_o;
   logic [NP*DW-1:0] rf_wdata_o;
   logic             csr_valid_o, pc_valid_o, pending_o;
   logic [CW-1:0]    csr_o;
   logic [DW-1:0]    pc_o;
   logic [CNTW-1:0]  discard_cnt_o;

   always_comb begin
      addr_pk = '0;
      data_pk = '0;
      for (int p = 0; p < int'(NP); p++) begin
         addr_pk[p*AW +: AW] = addr[p];
         data_pk[p*DW +: DW] = data[p];
      end
   end

   hmr_backup_delay #(
      .NumWritePorts(NP), .AddrWidth(AW), .DataWidth(DW),
      .CsrWidth(CW), .DelayStages(DS), .CntWidth(CNTW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .backup_en_i(en), .mismatch_i(mm),
      .rf_we_i(we), .rf_waddr_i(addr_pk), .rf_wdata_i(data_pk),
      .csr_valid_i(csr_v), .csr_i(csr), .pc_valid_i(pc_v), .pc_i(pc),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .csr_valid_o(csr_valid_o), .csr_o(csr_o), .pc_valid_o(pc_valid_o), .pc_o(pc_o),
      .pending_o(pending_o), .clear_cnt_i(clr), .discard_cnt_o(discard_cnt_o)
   );

   // History of what each cycle handed to the pipeline, indexed by cycle number.
   logic [NP-1:0] h_we   [MAXC];
   logic [AW-1:0] h_addr [MAXC][NP];
   logic [DW-1:0] h_data [MAXC][NP];
   logic          h_csrv [MAXC];
   logic          h_pcv  [MAXC];
   logic          h_mm   [MAXC];
   logic [CW-1:0] h_csr  [MAXC];
   logic [DW-1:0] h_pc   [MAXC];

   int t = 0, epoch = 0, cnt_exp = 0, checks = 0, errors = 0;

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, t);
      end
   endtask

   // A port's write survives unless some higher port writes the same address this cycle.
   function automatic logic [NP-1:0] winners();
      logic [NP-1:0] w;
      w = we;
      for (int i = 0; i < int'(NP); i++)
         for (int j = i + 1; j < int'(NP); j++)
            if (we[j] && addr[j] == addr[i]) w[i] = 1'b0;
      return w;
   endfunction

   function automatic bit clean(input int first, input int last);
      for (int k = first; k <= last; k++) if (h_mm[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic idle_n();
      n_en = 1'b1; n_mm = 1'b0; n_clr = 1'b0; n_we = '0; n_csrv = 1'b0; n_pcv = 1'b0;
      n_csr = '0; n_pc = '0;
      for (int p = 0; p < int'(NP); p++) begin n_addr[p] = '0; n_data[p] = '0; end
   endtask

   task automatic step();
      logic [NP-1:0] win, ew;
      bit cap, vc, pend;
      int c, inc, v;
      @(posedge clk); #1;
      en = n_en; mm = n_mm; clr = n_clr; we = n_we; csr_v = n_csrv; csr = n_csr;
      pc_v = n_pcv; pc = n_pc;
      for (int p = 0; p < int'(NP); p++) begin addr[p] = n_addr[p]; data[p] = n_data[p]; end
      win = winners();
      cap = en && !mm;
      h_mm[t] = mm; h_we[t] = cap ? win : '0;
      h_csrv[t] = cap && csr_v; h_pcv[t] = cap && pc_v; h_csr[t] = csr; h_pc[t] = pc;
      for (int p = 0; p < int'(NP); p++) begin h_addr[t][p] = addr[p]; h_data[t][p] = data[p]; end
      @(negedge clk);
      c = t - L;
      vc = 1'b0;
      if (c >= epoch) vc = clean(c, t);
      ew = vc ? h_we[c] : '0;
      check("rf_we", CW'(rf_we_o), CW'(ew));
      for (int p = 0; p < int'(NP); p++) begin
         if (ew[p]) begin
            check("rf_waddr", CW'(rf_waddr_o[p*AW +: AW]), CW'(h_addr[c][p]));
            check("rf_wdata", CW'(rf_wdata_o[p*DW +: DW]), CW'(h_data[c][p]));
         end
      end
      check("csr_valid", CW'(csr_valid_o), CW'(vc && h_csrv[c]));
      if (vc && h_csrv[c]) check("csr", csr_o, h_csr[c]);
      check("pc_valid", CW'(pc_valid_o), CW'(vc && h_pcv[c]));
      if (vc && h_pcv[c]) check("pc", CW'(pc_o), CW'(h_pc[c]));
      pend = 1'b0; inc = 0;
      for (int c2 = t - L; c2 <= t - 1; c2++) begin
         if (c2 >= epoch && clean(c2, t - 1)) begin
            pend = pend || (|h_we[c2]) || h_csrv[c2] || h_pcv[c2];
            inc += $countones(h_we[c2]);
         end
      end
      check("pending", CW'(pending_o), CW'(pend));
      check("discard_cnt", CW'(discard_cnt_o), CW'(cnt_exp));
      if (en) inc += $countones(win);
      if (clr) cnt_exp = mm ? ((inc > CNTMAX) ? CNTMAX : inc) : 0;
      else if (mm) begin
         v = cnt_exp + inc;
         cnt_exp = (v > CNTMAX) ? CNTMAX : v;
      end
      t++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; mm = 1'b0; clr = 1'b0; we = '0; csr_v = 1'b0; pc_v = 1'b0;
      #1;
      check("rst_we", CW'(rf_we_o), '0);
      check("rst_waddr", CW'(rf_waddr_o), '0);
      check("rst_wdata", CW'(rf_wdata_o), '0);
      check("rst_csr_valid", CW'(csr_valid_o), '0);
      check("rst_csr", csr_o, '0);
      check("rst_pc_valid", CW'(pc_valid_o), '0);
      check("rst_pc", CW'(pc_o), '0);
      check("rst_pending", CW'(pending_o), '0);
      check("rst_cnt", CW'(discard_cnt_o), '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      epoch = t;
      cnt_exp = 0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mm = 1'b0; clr = 1'b0; we = '0; csr_v = 1'b0; pc_v = 1'b0;
      csr = '0; pc = '0;
      for (int p = 0; p < int'(NP); p++) begin addr[p] = '0; data[p] = '0; end
      idle_n();
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();

      // Single write commits one cycle later, for exactly one cycle.
      idle_n(); n_we = 2'b01; n_addr[0] = 5'd5; n_data[0] = 32'hDEADBEEF; step();
      check("A_c0_we", CW'(rf_we_o), CW'(2'b00));
      idle_n(); step();
      check("A_we", CW'(rf_we_o), CW'(2'b01));
      check("A_addr", CW'(rf_waddr_o[AW-1:0]), CW'(5'd5));
      check("A_data", CW'(rf_wdata_o[DW-1:0]), CW'(32'hDEADBEEF));
      check("A_pend", CW'(pending_o), CW'(1'b1));
      idle_n(); step();
      check("A_gone", CW'(rf_we_o), CW'(2'b00));

      // Mismatch pulse in cycle 3 of a back-to-back write stream.
      idle_n(); n_clr = 1'b1; step();
      for (int i = 0; i < 7; i++) begin
         idle_n(); n_we = 2'b01; n_addr[0] = AW'(i); n_data[0] = 32'h100 + 32'(i);
         n_mm = (i == 3); step();
         if (i == 3 || i == 4) check("B_nocommit", CW'(rf_we_o), CW'(2'b00));
         if (i == 4) check("B_cnt", CW'(discard_cnt_o), CW'(2));
         if (i == 5) begin
            check("B_resume", CW'(rf_we_o), CW'(2'b01));
            check("B_data", CW'(rf_wdata_o[DW-1:0]), CW'(32'h104));
         end
      end

      // Both ports write address 7: only port 1 commits.
      idle_n(); n_we = 2'b11; n_addr[0] = 5'd7; n_addr[1] = 5'd7;
      n_data[0] = 32'h1; n_data[1] = 32'h2; step();
      idle_n(); step();
      check("C_we", CW'(rf_we_o), CW'(2'b10));
      check("C_data", CW'(rf_wdata_o[2*DW-1:DW]), CW'(32'h2));
      check("C_cnt", CW'(discard_cnt_o), CW'(2));

      // Saturation, then clear coinciding with a two-write discard.
      idle_n(); n_clr = 1'b1; step();
      repeat (8) begin
         idle_n(); n_we = 2'b11; n_addr[0] = 5'd1; n_addr[1] = 5'd2; n_mm = 1'b1; step();
      end
      idle_n(); step();
      check("D_sat", CW'(discard_cnt_o), CW'(15));
      idle_n(); n_clr = 1'b1; n_mm = 1'b1; n_we = 2'b11; n_addr[0] = 5'd1; n_addr[1] = 5'd2; step();
      idle_n(); step();
      check("D_clr_mm", CW'(discard_cnt_o), CW'(2));

      // Capture disabled: in-flight item still commits, nothing new enters.
      idle_n(); n_we = 2'b01; n_addr[0] = 5'd9; n_data[0] = 32'hE0; step();
      idle_n(); n_en = 1'b0; n_we = 2'b11; n_addr[0] = 5'd10; n_addr[1] = 5'd11; step();
      check("E_commit", CW'(rf_we_o), CW'(2'b01));
      check("E_pend", CW'(pending_o), CW'(1'b1));
      idle_n(); n_en = 1'b0; n_we = 2'b11; step();
      check("E_none", CW'(rf_we_o), CW'(2'b00));
      check("E_pend_low", CW'(pending_o), CW'(1'b0));

      // Reset with two writes in flight.
      idle_n(); n_we = 2'b11; n_addr[0] = 5'd3; n_addr[1] = 5'd4;
      n_data[0] = 32'hA; n_data[1] = 32'hB; step();
      idle_n(); step();
      check("F_pre", CW'(rf_we_o), CW'(2'b11));
      do_reset();
      idle_n(); step();
      check("F_after", CW'(rf_we_o), CW'(2'b00));
      idle_n(); step();
      check("F_after2", CW'(rf_we_o), CW'(2'b00));

      // Random traffic with narrow addresses to provoke collisions.
      repeat (400) begin
         n_en  = ($urandom % 10) != 0;
         n_mm  = ($urandom % 10) == 0;
         n_clr = ($urandom % 20) == 0;
         n_we  = NP'($urandom);
         for (int p = 0; p < int'(NP); p++) begin
            n_addr[p] = AW'($urandom % 4);
            n_data[p] = $urandom;
         end
         n_csrv = $urandom % 2;
         n_csr  = {$urandom, $urandom, $urandom, $urandom};
         n_pcv  = $urandom % 2;
         n_pc   = $urandom;
         step();
         if (($urandom % 150) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hmr_backup_delay.md
# hmr_backup_delay

Parametrised delay-and-commit pipeline for the rapid-recovery backup state of one cluster core (regfile writes, CSR snapshot, PC). It holds every backup item for a fixed number of cycles and forwards it to the recovery storage only if the lockstep comparator raised no mismatch in the meantime. A mismatch flushes all in-flight items, so corrupted values never reach the checkpoint. One instance sits between each HMR-protected core group and its recovery regfile/CSR/PC storage.

## Interface

Parameters:
- NumWritePorts, default 2: regfile write ports tracked (1..4).
- AddrWidth, default 5: regfile address width.
- DataWidth, default 32: regfile data and PC width.
- CsrWidth, default 128: packed CSR snapshot width.
- DelayStages, default 2: commit latency in cycles (1..8; 0 is illegal and is rejected by an elaboration assertion).
- CntWidth, default 16: discard counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- backup_en_i  in  1  capture enable; when low, no new items enter the pipeline.
- mismatch_i  in  1  lockstep mismatch from the HMR comparator.
- rf_we_i  in  NumWritePorts  per-port write enable.
- rf_waddr_i  in  NumWritePorts×AddrWidth  per-port address.
- rf_wdata_i  in  NumWritePorts×DataWidth  per-port data.
- csr_valid_i / csr_i  in  1 / CsrWidth  CSR snapshot.
- pc_valid_i / pc_i  in  1 / DataWidth  PC backup.
- rf_we_o / rf_waddr_o / rf_wdata_o  out  same widths as inputs  committed writes.
- csr_valid_o / csr_o  out  1 / CsrWidth  committed CSR snapshot.
- pc_valid_o / pc_o  out  1 / DataWidth  committed PC.
- pending_o  out  1  at least one valid item is in flight.
- clear_cnt_i  in  1  synchronous clear of the discard counter.
- discard_cnt_o  out  CntWidth  saturating count of flushed regfile writes.

## Operation

- Stage 0 captures the inputs when `backup_en_i=1` and `mismatch_i=0`. Each stage carries its own valid bit per item: one bit per write port, one for the CSR and one for the PC.
- Same-cycle address collision: if ports i<j both have `we=1` and equal addresses, port i's `we` is cleared at capture, so the highest-index port wins. A suppressed write does not count as a discard.
- Every cycle each stage shifts to the next. There is no backpressure, because the recovery storage always accepts.
- Outputs are driven from the last stage, with every valid gated by `~mismatch_i`. Data and address outputs show the last-stage contents regardless of the valid bits.
- Mismatch in cycle t:
  - All stage valids clear at the next edge.
  - Output valids are 0 in cycle t.
  - Inputs presented in cycle t are dropped.
- Discard counter:
  - In a mismatch cycle it adds the popcount of the valid `rf_we` bits across all stages, plus the `rf_we_i` bits that would have been captured in that cycle.
  - It saturates at all-ones.
  - `clear_cnt_i` resets it to 0. If a clear and a mismatch occur in the same cycle, the result is that cycle's increment alone.
- `pending_o` is the OR of all valid bits in all stages (it is not gated by mismatch).
- `backup_en_i=0` does not flush. Items already in flight still commit.

## Timing

- Reset: all stage valids, all outputs and `discard_cnt_o` are 0; `pending_o=0`.
- Latency: an item captured at edge t becomes visible on the outputs during cycle t+DelayStages−1, and commits in that cycle when `mismatch_i=0`. For DelayStages=2, an input in cycle 0 appears as an output in cycle 1.
- Throughput: one full item set per cycle, back to back.
- Consecutive mismatch cycles: every one of them flushes, and nothing commits until DelayStages clean cycles have followed the last mismatch.
- Reset asserted mid-operation: all in-flight items are lost with no commit, and the counter is not updated.

## Test plan

- DelayStages=2: write (addr 5, 0xDEADBEEF) on port 0 in cycle 0 -> `rf_we_o[0]=1` with addr 5 / 0xDEADBEEF in cycle 1 only; `pending_o=1` in cycle 1.
- Write port 0 every cycle, `mismatch_i` pulsed in cycle 3 -> no commit in cycle 3 or cycle 4; commits resume in cycle 5; `discard_cnt_o=2` (one in-flight write plus the cycle-3 input).
- Ports 0 and 1 both write addr 7 (0x1 and 0x2) -> only `rf_we_o[1]` commits, with 0x2; counter unchanged.
- CntWidth=4: more than 15 writes discarded -> counter holds at 0xF. Clear together with a mismatch discarding 2 writes -> counter reads 2.
- `backup_en_i=0` while items are in flight -> in-flight items still commit; no new items enter; `pending_o` falls after DelayStages cycles.
- `rst_ni` asserted with 2 items in flight -> all outputs and the counter read 0 immediately; no commit occurs after reset is released.
